// File: rtl/operand_pkg.sv
// operand_pkg: shared limits and slice helper for the operand register pipeline.
package operand_pkg;
    localparam int MIN_DEPTH = 1;
    localparam int MIN_PORTS = 1;

    function automatic int slice_base(input int p, input int w);
        return p * w;
    endfunction
endpackage

// File: rtl/operand_delay_line.sv
// operand_delay_line: DEPTH-stage data/valid shift pipeline with stall and flush.
module operand_delay_line #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    // flush outranks stall so a stalled pipeline can still be cleared
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
            valid_q <= '0;
        end else if (!stall) begin
            data_q[0]  <= in_data;
            valid_q[0] <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
endmodule

// File: rtl/operand_reg_pipe.sv
// operand_reg_pipe: operand holding register fanned out to NUM_PORTS aligned delay lines.
module operand_reg_pipe
    import operand_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 2,
    parameter int DEPTH      = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            load,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            stall,
    input  logic                            flush,
    input  logic [NUM_PORTS-1:0]            port_en,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_PORTS-1:0]            valid_out,
    output logic                            hold_valid
);
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] inj_data;
    logic                  inj_on;

    if (DEPTH < MIN_DEPTH || NUM_PORTS < MIN_PORTS) begin : g_bad_params
        $error("operand_reg_pipe: DEPTH and NUM_PORTS must both be >= 1");
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q     <= '0;
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_q     <= data_in;
            hold_valid <= 1'b1;
        end
    end

    // bypass lets a fresh load enter the pipelines on the same edge it is held
    always_comb begin
        inj_data = load ? data_in : hold_q;
        inj_on   = load | hold_valid;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        operand_delay_line #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_line (
            .clk      (clk),
            .reset_n  (reset_n),
            .stall    (stall),
            .flush    (flush),
            .in_data  (inj_data),
            .in_valid (inj_on & port_en[p]),
            .out_data (data_out[slice_base(p, DATA_WIDTH) +: DATA_WIDTH]),
            .out_valid(valid_out[p])
        );
    end
endmodule

// File: tb/tb_operand_reg_pipe.sv
// tb_operand_reg_pipe: directed checks of the operand register pipeline at DEPTH=3, NUM_PORTS=4.
module tb_operand_reg_pipe;
    localparam int W = 32;
    localparam int N = 4;
    localparam int D = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             load;
    logic [W-1:0]     data_in;
    logic             stall;
    logic             flush;
    logic [N-1:0]     port_en;
    logic [N*W-1:0]   data_out;
    logic [N-1:0]     valid_out;
    logic             hold_valid;
    int               n_cmp = 0;
    int               n_bad = 0;

    operand_reg_pipe #(.DATA_WIDTH(W), .NUM_PORTS(N), .DEPTH(D)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .data_in   (data_in),
        .stall     (stall),
        .flush     (flush),
        .port_en   (port_en),
        .data_out  (data_out),
        .valid_out (valid_out),
        .hold_valid(hold_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
        return {N{v}};
    endfunction

    initial begin
        reset_n = 1'b0; load = 1'b0; data_in = '0; stall = 1'b0; flush = 1'b0; port_en = '1;
        tick(); tick();
        check("reset_data", data_out, '0);
        check("reset_valid", valid_out, '0);
        check("reset_hold", hold_valid, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle", {hold_valid, valid_out, data_out}, '0);
        end
        // single load: visible after DEPTH edges including the load edge
        load = 1'b1; data_in = 32'hDEADBEEF;
        tick();
        load = 1'b0;
        check("load_hold", hold_valid, 1'b1);
        check("load_lat0", valid_out, '0);
        tick();
        check("load_lat1", valid_out, '0);
        tick();
        check("load_valid", valid_out, 4'hF);
        check("load_data", data_out, rep(32'hDEADBEEF));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("load_steady", {valid_out, data_out}, {4'hF, rep(32'hDEADBEEF)});
        end
        // back-to-back loads
        load = 1'b1; data_in = 32'h11;
        tick();
        data_in = 32'h22;
        tick();
        load = 1'b0;
        check("b2b_old", data_out, rep(32'hDEADBEEF));
        tick();
        check("b2b_first", data_out, rep(32'h11));
        tick();
        check("b2b_second", data_out, rep(32'h22));
        // stall with a load underneath
        load = 1'b1; data_in = 32'hA5;
        tick();
        load = 1'b0;
        tick(); tick();
        check("pre_stall", {valid_out, data_out}, {4'hF, rep(32'hA5)});
        stall = 1'b1; load = 1'b1; data_in = 32'h5A;
        tick();
        load = 1'b0;
        check("stall_0", {valid_out, data_out}, {4'hF, rep(32'hA5)});
        tick();
        check("stall_1", data_out, rep(32'hA5));
        tick();
        check("stall_2", data_out, rep(32'hA5));
        stall = 1'b0;
        tick();
        check("unstall_1", data_out, rep(32'hA5));
        tick();
        check("unstall_2", data_out, rep(32'hA5));
        tick();
        check("unstall_3", {valid_out, data_out}, {4'hF, rep(32'h5A)});
        // flush wins over stall
        load = 1'b1; data_in = 32'h77;
        tick();
        load = 1'b0;
        tick(); tick();
        check("pre_flush", data_out, rep(32'h77));
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        check("flush_valid", valid_out, '0);
        check("flush_data", data_out, '0);
        check("flush_hold", hold_valid, 1'b1);
        tick();
        check("reflush_1", valid_out, '0);
        tick();
        check("reflush_2", valid_out, '0);
        tick();
        check("reflush_3", {valid_out, data_out}, {4'hF, rep(32'h77)});
        // partial port enable
        port_en = 4'b0101; load = 1'b1; data_in = 32'h33;
        tick();
        load = 1'b0;
        tick(); tick();
        check("pen_valid", valid_out, 4'b0101);
        check("pen_data", data_out, rep(32'h33));
        // load with flush
        load = 1'b1; flush = 1'b1; data_in = 32'h99; port_en = '1;
        tick();
        load = 1'b0; flush = 1'b0;
        check("lflush_valid", valid_out, '0);
        tick(); tick();
        check("lflush_wait", valid_out, '0);
        tick();
        check("lflush_data", {valid_out, data_out}, {4'hF, rep(32'h99)});
        // reset mid-stream
        reset_n = 1'b0;
        tick();
        check("mid_reset", {hold_valid, valid_out, data_out}, '0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_reset", {hold_valid, valid_out, data_out}, '0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
